// File: rtl/cache_ctrl.sv
// cache_ctrl: lookup/refill sequencer for a 4-line direct-mapped cache with
// 6-bit tags. Address layout: addr[7:2] = tag, addr[1:0] = line.
//
// Handshakes:
//   cpu_req/cpu_rdy is request/complete. cpu_req is a level the CPU holds,
//   with cpu_addr stable, until cpu_rdy, which is a one-cycle pulse.
//   cpu_hit is meaningful only while cpu_rdy=1.
//   mem_req/mem_ack is request/complete. mem_req is a level with mem_addr
//   stable. mem_ack is a one-cycle pulse and is honoured only in REFILL.
module cache_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic [7:0] cpu_addr,
  input  logic       flush,
  output logic       cpu_rdy,
  output logic       cpu_hit,
  output logic       busy,
  output logic [1:0] tag_line,
  output logic [5:0] tag_din,
  output logic       tag_wr,
  input  logic [5:0] tag_dout,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  output logic [7:0] hit_cnt,
  output logic [7:0] miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_REFILL    = 3'd2,
    S_UPDATE    = 3'd3,
    S_DONE_HIT  = 3'd4,
    S_DONE_MISS = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [3:0]  valid_q, valid_d;
  logic [7:0]  hit_cnt_q, hit_cnt_d;
  logic [7:0]  miss_cnt_q, miss_cnt_d;
  logic        lookup_hit;

  // Hit test against the tag array's combinational read of the latched line.
  assign lookup_hit = valid_q[addr_q[1:0]] && (tag_dout == addr_q[7:2]);

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= 8'd0;
      valid_q    <= 4'd0;
      hit_cnt_q  <= 8'd0;
      miss_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Next-state logic; flush takes priority over a request in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!flush && cpu_req) state_d = S_LOOKUP;
      end
      S_LOOKUP:    state_d = lookup_hit ? S_DONE_HIT : S_REFILL;
      S_REFILL: begin
        if (mem_ack) state_d = S_UPDATE;
      end
      S_UPDATE:    state_d = S_DONE_MISS;
      S_DONE_HIT:  state_d = S_IDLE;
      S_DONE_MISS: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath updates: address latch, valid bits and saturating counters.
  always_comb begin
    addr_d     = addr_q;
    valid_d    = valid_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (flush) valid_d = 4'd0;
        else if (cpu_req) addr_d = cpu_addr;
      end
      S_LOOKUP: begin
        if (lookup_hit) begin
          if (hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
        end else begin
          if (miss_cnt_q != 8'hFF) miss_cnt_d = miss_cnt_q + 8'd1;
        end
      end
      S_UPDATE: valid_d[addr_q[1:0]] = 1'b1;
      default: ;
    endcase
  end

  // Output decode from registered state; only tag_line sees cpu_addr, in IDLE.
  always_comb begin
    cpu_rdy  = 1'b0;
    cpu_hit  = 1'b0;
    tag_wr   = 1'b0;
    mem_req  = 1'b0;
    busy     = (state_q != S_IDLE);
    tag_line = (state_q == S_IDLE) ? cpu_addr[1:0] : addr_q[1:0];
    tag_din  = addr_q[7:2];
    mem_addr = addr_q;
    case (state_q)
      S_REFILL:    mem_req = 1'b1;
      S_UPDATE:    tag_wr  = 1'b1;
      S_DONE_HIT: begin
        cpu_rdy = 1'b1;
        cpu_hit = 1'b1;
      end
      S_DONE_MISS: cpu_rdy = 1'b1;
      default: ;
    endcase
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Lookup/refill sequencer for the 4-line, 6-bit-tag direct-mapped cache. It accepts one 8-bit CPU address at a time and drives the tag array's line select, write enable and write data. It keeps the per-line valid bits, reports hit or miss, runs a req/ack refill handshake with the next-level memory on a miss, and counts hits and misses. It sits between the CPU load port, the tag array and the memory interface.

## Interface
- No parameters. Geometry is fixed: address[7:2] = tag, address[1:0] = line.
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cpu_req  in  1  access request; level, held until cpu_rdy
- cpu_addr  in  8  access address; must be stable while cpu_req=1
- flush  in  1  invalidate all lines; acted on only in IDLE
- cpu_rdy  out  1  one-cycle pulse: access complete
- cpu_hit  out  1  valid only with cpu_rdy: 1 = hit, 0 = miss serviced
- busy  out  1  high in every state except IDLE
- tag_line  out  2  tag array line select (read and write)
- tag_din  out  6  tag array write data
- tag_wr  out  1  tag array write enable (captured on clk edge)
- tag_dout  in  6  tag array combinational read data for tag_line
- mem_req  out  1  refill request; level
- mem_addr  out  8  refill address (tag, line), stable while mem_req=1
- mem_ack  in  1  one-cycle refill completion from memory
- hit_cnt  out  8  saturating hit counter
- miss_cnt  out  8  saturating miss counter

## Operation
- Internal registers: addr_q[7:0] (latched address), valid[3:0], 3-bit state.
- tag_line = cpu_addr[1:0] in IDLE, otherwise addr_q[1:0]. tag_din = addr_q[7:2]. mem_addr = addr_q.
- State IDLE:
  - If flush=1: valid <= 0. Stay in IDLE. A pending cpu_req waits; flush has priority over cpu_req.
  - Else if cpu_req=1: addr_q <= cpu_addr, go to LOOKUP.
- State LOOKUP: hit = valid[addr_q[1:0]] && (tag_dout == addr_q[7:2]).
  - On hit: hit_cnt++, go to DONE_HIT.
  - On miss: miss_cnt++, go to REFILL.
- State REFILL: mem_req=1. On mem_ack=1, go to UPDATE. There is no timeout; the controller waits indefinitely.
- State UPDATE: tag_wr=1 for exactly one cycle; valid[addr_q[1:0]] <= 1; go to DONE_MISS.
- State DONE_HIT / DONE_MISS: cpu_rdy=1, with cpu_hit=1 or 0 respectively. Go to IDLE.
- Counters stop at 255 and do not wrap.
- The tag array's own reset contents are irrelevant: valid=0 after reset, so the first access to every line misses.
- tag_wr is asserted only in UPDATE. mem_req is asserted only in REFILL.
- cpu_req deasserted mid-transaction is ignored. The transaction completes and updates the cache.
- mem_ack outside REFILL is ignored.
- flush outside IDLE is ignored. It is not queued; the requester holds it until busy=0.

## Timing
- Reset (asynchronous, immediate): state=IDLE, valid=0, addr_q=0, hit_cnt=0, miss_cnt=0. All outputs then read: cpu_rdy=0, cpu_hit=0, busy=0, tag_wr=0, mem_req=0, tag_din=0, mem_addr=0, and tag_line follows cpu_addr[1:0].
- Reset mid-transaction aborts the transaction: mem_req drops immediately and no tag write occurs.
- Outputs are decoded from registered state. Except for tag_line in IDLE, there is no combinational path from inputs to outputs.
- Hit latency, with cpu_req sampled at edge 0:
  - LOOKUP during cycle 1.
  - cpu_rdy=1, cpu_hit=1 during cycle 2.
  - IDLE during cycle 3.
- Miss latency:
  - mem_req rises in cycle 2.
  - mem_ack sampled at edge k.
  - UPDATE (tag_wr) in cycle k+1.
  - cpu_rdy=1, cpu_hit=0 in cycle k+2.
  - With mem_ack in the first REFILL cycle (k=2), cpu_rdy comes in cycle 4.
- Back-to-back accesses: cpu_req still high in the cycle after cpu_rdy starts a new access. This gives at most one access per 3 cycles.
- Counters update at the edge that leaves LOOKUP.

## Test plan
- Cold miss then hit:
  - Reset, then read 0x0D (tag 0x03, line 1), mem_ack after 2 REFILL cycles. Required: mem_req with mem_addr=0x0D, tag_wr with tag_line=1 and tag_din=0x03, cpu_rdy with cpu_hit=0, miss_cnt=1.
  - Read 0x0D again. Required: cpu_rdy in the 2nd cycle after sampling, cpu_hit=1, no mem_req, hit_cnt=1.
- Conflict:
  - Fill 0x0D, then read 0x11 (tag 0x04, line 1). Required: miss, tag_din=0x04.
  - Re-read 0x0D. Required: miss again, miss_cnt=3.
- Flush priority:
  - Fill lines 0 to 3, assert flush and cpu_req(0x0C) in the same IDLE cycle. Required: valid cleared first, then the access misses.
  - Flush asserted during REFILL. Required: no effect.
- Reset mid-refill:
  - Assert reset while mem_req=1. Required: mem_req=0, busy=0, counters 0, and the next access to the same address misses.
- Saturation:
  - 300 repeated hits to one address. Required: hit_cnt stops at 255.
- Handshake robustness:
  - Spurious mem_ack in IDLE. Required: ignored.
  - mem_ack delayed 20 cycles. Required: mem_req and mem_addr stable throughout, exactly one tag_wr pulse.
